apb_wait_slave_mem: RTL

- Downstream APB3 completer for one PSEL slot of the APB-to-APB bridge BFM. Consumes PSEL/PADDR/PWRITE/PENABLE/PWDATA and produces PRDATA/PREADY/PSLVERR.
- Provides a word-addressed 32-bit memory with a fixed, parameterised number of wait states and an error response for out-of-range addresses.
- Keeps transfer and error counters that the bench inspects for bridge verification.

---
 rtl/apb_wait_slave_mem.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/apb_wait_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_wait_slave_mem
//
// APB3 completer for one PSEL slot of a bridge test environment. It provides a
// word-addressed 32-bit memory that answers every transfer after a fixed
// number of wait states. Addresses past the end of the memory get an error
// response. Two counters track completed transfers and error completions.
//
// Parameters
//   AWIDTH      memory word-address width; DEPTH = 2**AWIDTH words
//   WAIT_CYCLES wait states before PREADY, 0..15
//   SLOT_BITS   PADDR bits decoded inside the slot (upper bits ignored)
//
// Ports
//   PCLK        clock, rising edge
//   PRESET      synchronous active-high reset
//   PSEL        slot select
//   PADDR       byte address; [1:0] and [31:SLOT_BITS] ignored
//   PWRITE      1 = write, 0 = read
//   PENABLE     access phase
//   PWDATA      write data
//   PRDATA      read data, non-zero only while PREADY=1
//   PREADY      one-cycle completion pulse
//   PSLVERR     out-of-range error, only while PREADY=1
//   XFER_COUNT  completed transfers, wraps
//   ERR_COUNT   completed error transfers, saturates at 0xFF
// -----------------------------------------------------------------------------
module apb_wait_slave_mem #(
  parameter int AWIDTH      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int SLOT_BITS   = 24
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [15:0] XFER_COUNT,
  output logic [7:0]  ERR_COUNT
);

  localparam int              DEPTH   = 2**AWIDTH;
  localparam int              IDX_W   = SLOT_BITS - 2;
  localparam logic [31:0]     DEPTH_W = 32'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [AWIDTH-1:0] cap_idx;
  logic              cap_write;
  logic              cap_oor;
  logic [31:0]       cap_wdata;
  logic [31:0]       mem [DEPTH];

  logic [IDX_W-1:0]  setup_idx;
  logic              setup_oor;
  logic [31:0]       setup_rdata;
  logic [31:0]       access_rdata;
  logic              do_write;

  // Address bits outside the decoded slot window are deliberately unused.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, PADDR[31:SLOT_BITS], PADDR[1:0]};

  // NOTE: every signal assigned here gets a value on every path first, so no
  // latch can be inferred.
  always_comb begin
    setup_idx    = PADDR[SLOT_BITS-1:2];
    setup_oor    = (32'(setup_idx) >= DEPTH_W);
    setup_rdata  = '0;
    access_rdata = '0;
    // With zero wait states the response is formed from the live setup-phase
    // bus; otherwise from the captured transfer.
    if (!PWRITE && !setup_oor) setup_rdata  = mem[setup_idx[AWIDTH-1:0]];
    if (!cap_write && !cap_oor) access_rdata = mem[cap_idx];
    do_write = !PRESET && (state == ACCESS) && PREADY && cap_write && !cap_oor;
  end

  // NOTE: the memory array has no reset; its contents survive PRESET and only
  // the completion edge of an in-range write changes it.
  always_ff @(posedge PCLK) begin
    if (do_write) mem[cap_idx] <= cap_wdata;
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cap_idx    <= '0;
      cap_write  <= 1'b0;
      cap_oor    <= 1'b0;
      cap_wdata  <= '0;
      PREADY     <= 1'b0;
      PSLVERR    <= 1'b0;
      PRDATA     <= '0;
      XFER_COUNT <= '0;
      ERR_COUNT  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // An access phase without a preceding setup phase is ignored.
          if (PSEL && !PENABLE) begin
            state     <= ACCESS;
            cap_idx   <= setup_idx[AWIDTH-1:0];
            cap_write <= PWRITE;
            cap_oor   <= setup_oor;
            cap_wdata <= PWDATA;
            if (WAIT_CYCLES == 0) begin
              wait_cnt <= '0;
              PREADY   <= 1'b1;
              PSLVERR  <= setup_oor;
              PRDATA   <= setup_rdata;
            end else begin
              wait_cnt <= 4'(WAIT_CYCLES);
            end
          end
        end

        ACCESS: begin
          if (PREADY) begin
            // Completion cycle: retire the transfer and clear the response.
            state      <= IDLE;
            PREADY     <= 1'b0;
            PSLVERR    <= 1'b0;
            PRDATA     <= '0;
            XFER_COUNT <= XFER_COUNT + 16'd1;
            if (PSLVERR && (ERR_COUNT != 8'hFF)) ERR_COUNT <= ERR_COUNT + 8'd1;
          end else if (!PSEL) begin
            // Abort: drop the transfer without touching memory or counters.
            state   <= IDLE;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
          end else if (PENABLE) begin
            wait_cnt <= wait_cnt - 4'd1;
            // Counter at 1 means this is the last wait cycle.
            if (wait_cnt == 4'd1) begin
              PREADY  <= 1'b1;
              PSLVERR <= cap_oor;
              PRDATA  <= access_rdata;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
